// File: rtl/aes_pkg.sv
// Shared AES constants and types for the key schedule and cipher datapath.
package aes_pkg;

    localparam int unsigned NK     = 6;
    localparam int unsigned NR     = 12;
    localparam int unsigned NW     = 4 * (NR + 1);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned IDX_W  = 6;

    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1b;

    typedef logic [0:WORD_W-1] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } ks_state_e;

endpackage

// File: rtl/aes_sbox.sv
// Combinational FIPS-197 forward S-box, one byte per instance.
module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    // Byte n of the table sits at bits [8n +: 8], entry 0x00 leftmost.
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign dout = SBOX[{din, 3'b000} +: 8];

endmodule

// File: rtl/key_sched_192_ctrl.sv
// Sequential AES-192 key expansion: one word per cycle through a shared
// SubWord path, with all 52 words held for round-key reads.
module key_sched_192_ctrl
    import aes_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [0:191]   key,
    output logic           busy,
    output logic           key_ready,
    input  logic [3:0]     rk_idx,
    output logic [0:127]   rk
);

    ks_state_e        state_q, state_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic [IDX_W-1:0] i_q, i_d;
    logic [2:0]       imod_q, imod_d;
    logic [7:0]       rcon_q, rcon_d;
    logic             load, wr_en;

    word_t            w [NW];
    word_t            prev, rot, sub, temp, new_word;
    logic [7:0]       sb_out [4];
    logic [7:0]       rcon_next;
    logic [IDX_W-1:0] rk_base;

    // Shared SubWord path applied to RotWord(w[i-1]).
    assign prev = w[i_q - IDX_W'(1)];
    assign rot  = {prev[8:31], prev[0:7]};

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .din  (rot[8*b +: 8]),
            .dout (sb_out[b])
        );
    end

    assign sub       = {sb_out[0], sb_out[1], sb_out[2], sb_out[3]};
    assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? RCON_POLY : 8'h00);
    assign temp      = (imod_q == 3'd0) ? (sub ^ {rcon_q, 24'h000000}) : prev;
    assign new_word  = w[i_q - IDX_W'(NK)] ^ temp;

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        i_d     = i_q;
        imod_d  = imod_q;
        rcon_d  = rcon_q;
        load    = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            IDLE, READY: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = EXPAND;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                    i_d     = IDX_W'(NK);
                    imod_d  = 3'd0;
                    rcon_d  = RCON_INIT;
                end
            end
            EXPAND: begin
                wr_en  = 1'b1;
                i_d    = i_q + IDX_W'(1);
                imod_d = (imod_q == 3'(NK - 1)) ? 3'd0 : imod_q + 3'd1;
                if (imod_q == 3'd0) begin
                    rcon_d = rcon_next;
                end
                if (i_q == IDX_W'(NW - 1)) begin
                    state_d = READY;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            i_q     <= IDX_W'(NK);
            imod_q  <= 3'd0;
            rcon_q  <= RCON_INIT;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            i_q     <= i_d;
            imod_q  <= imod_d;
            rcon_q  <= rcon_d;
        end
    end

    // Word storage carries no reset; contents are only exposed once ready.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (load) begin
                for (int k = 0; k < NK; k++) begin
                    w[k] <= key[WORD_W*k +: WORD_W];
                end
            end else if (wr_en) begin
                w[i_q] <= new_word;
            end
        end
    end

    assign busy      = busy_q;
    assign key_ready = ready_q;
    assign rk_base   = {rk_idx, 2'b00};

    always_comb begin
        rk = '0;
        if (ready_q && (rk_idx <= 4'(NR))) begin
            rk = {w[rk_base], w[rk_base + IDX_W'(1)],
                  w[rk_base + IDX_W'(2)], w[rk_base + IDX_W'(3)]};
        end
    end

endmodule

// File: tb/tb_key_sched_192_ctrl.sv
// Directed bench for key_sched_192_ctrl using FIPS-197 A.2 vectors and a scoreboard queue.
module tb_key_sched_192_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [0:191] key;
    logic         busy;
    logic         key_ready;
    logic [3:0]   rk_idx;
    logic [0:127] rk;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    logic [127:0] exp_q [$];
    string        tag_q [$];

    localparam logic [0:191] KEY_A2    = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [0:191] KEY_OTHER = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;

    always #5 clk = ~clk;

    key_sched_192_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .key       (key),
        .busy      (busy),
        .key_ready (key_ready),
        .rk_idx    (rk_idx),
        .rk        (rk)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_check();
        chk(tag_q.pop_front(), rk, exp_q.pop_front());
    endtask

    // Pulse start with k, then count cycles until key_ready; optionally inject
    // a second start or a reset at a given cycle of the expansion.
    task automatic expand(input logic [0:191] k, input int inj_cycle,
                          input logic [0:191] inj_key, input int rst_cycle);
        int cnt      = 0;
        int busy_cnt = 0;
        bit done     = 1'b0;
        @(negedge clk);
        start = 1'b1;
        key   = k;
        if (rst_cycle < 0) begin
            exp_q.push_back(128'd47); tag_q.push_back("latency");
            exp_q.push_back(128'd46); tag_q.push_back("busy_cycles");
        end
        while (!done && cnt < 200) begin
            @(negedge clk);
            start = 1'b0;
            key   = ~k;
            cnt++;
            if (busy) busy_cnt++;
            if (cnt == 1) begin
                chk("accept_ready_low", 128'(key_ready), 128'd0);
                chk("accept_busy_high", 128'(busy), 128'd1);
            end
            if (cnt == inj_cycle) begin
                start = 1'b1;
                key   = inj_key;
            end
            if (cnt == rst_cycle) begin
                reset  = 1'b1;
                rk_idx = 4'd0;
                @(negedge clk);
                chk("rst_mid_busy", 128'(busy), 128'd0);
                chk("rst_mid_ready", 128'(key_ready), 128'd0);
                chk("rst_mid_rk", rk, 128'd0);
                reset = 1'b0;
                return;
            end
            if (key_ready) done = 1'b1;
        end
        chk(tag_q.pop_front(), 128'(cnt), exp_q.pop_front());
        chk(tag_q.pop_front(), 128'(busy_cnt), exp_q.pop_front());
    endtask

    task automatic rd(input string tag, input logic [3:0] idx, input logic [127:0] exp);
        @(negedge clk);
        rk_idx = idx;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        #1;
        sb_check();
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        key    = '0;
        rk_idx = 4'd0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 128'(busy), 128'd0);
        chk("reset_ready", 128'(key_ready), 128'd0);
        chk("reset_rk", rk, 128'd0);
        reset = 1'b0;

        // A.2 expansion and read sweep
        expand(KEY_A2, -1, '0, -1);
        rd("a2_rk0",  4'd0,  128'h8e73b0f7da0e6452c810f32b809079e5);
        rd("a2_rk1",  4'd1,  128'h62f8ead2522c6b7bfe0c91f72402f5a5);
        rd("a2_rk12", 4'd12, 128'he98ba06f448c773c8ecc720401002202);
        rd("a2_rk13", 4'd13, 128'd0);
        rd("a2_rk15", 4'd15, 128'd0);

        // Restart from READY with a start pulse injected mid-expansion
        expand(KEY_A2, 20, KEY_OTHER, -1);
        rd("inj_rk1",  4'd1,  128'h62f8ead2522c6b7bfe0c91f72402f5a5);
        rd("inj_rk12", 4'd12, 128'he98ba06f448c773c8ecc720401002202);

        // Reset mid-expansion, then a clean A.2 run
        expand(KEY_OTHER, -1, '0, 30);
        expand(KEY_A2, -1, '0, -1);
        rd("post_rst_rk0",  4'd0,  128'h8e73b0f7da0e6452c810f32b809079e5);
        rd("post_rst_rk12", 4'd12, 128'he98ba06f448c773c8ecc720401002202);

        // All-zero key from READY
        expand('0, -1, '0, -1);
        rd("zero_rk0", 4'd0, 128'd0);
        rd("zero_rk1", 4'd1, 128'h000000000000000062636363_62636363);

        // Reset and start together
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        key   = KEY_A2;
        @(negedge clk);
        chk("rst_start_busy", 128'(busy), 128'd0);
        chk("rst_start_ready", 128'(key_ready), 128'd0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_start_idle_busy", 128'(busy), 128'd0);
        chk("rst_start_idle_ready", 128'(key_ready), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
